// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared pipeline types for hazard detection and forwarding
package cpu_pipe_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // One in-flight instruction: valid, destination, writes-register, is-load
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dst;
        logic              wr;
        logic              ld;
    } trk_entry_t;

    // A producer entry matches a source register; register 0 never matches
    function automatic logic dst_match(input trk_entry_t e, input logic [REG_AW-1:0] r);
        return e.v & e.wr & (e.dst == r) & (r != '0);
    endfunction

endpackage

// File: rtl/pipe_dst_tracker.sv
// rtl/pipe_dst_tracker.sv - EX/MEM/WB destination tracker with bubble insert
module pipe_dst_tracker
    import cpu_pipe_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bubble_i,
    input  trk_entry_t id_entry_i,
    output trk_entry_t ex_o,
    output trk_entry_t mem_o,
    output trk_entry_t wb_o
);

    trk_entry_t ex_q, mem_q, wb_q;
    trk_entry_t ex_d;

    // The instruction entering EX is replaced by an all-zero entry on a bubble
    always_comb begin
        ex_d = bubble_i ? '0 : id_entry_i;
    end

    // Advance the three-stage shift every cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - load-use stall, ID/EX bubble and registered forwarding selects
module hazard_fwd_unit
    import cpu_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_read_rs,
    input  logic             id_read_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_reg_write,
    input  logic             id_lw,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    trk_entry_t id_entry, ex_e, mem_e, wb_e;
    logic       hz;
    logic [1:0] fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Youngest producer wins; WB needs no select because the regfile is write-through
    function automatic logic [1:0] fwd_sel(input logic rd, input logic [4:0] r,
                                           input trk_entry_t ex, input trk_entry_t mem);
        if (rd && dst_match(ex, r))  return FWD_EXMEM;
        if (rd && dst_match(mem, r)) return FWD_MEMWB;
        return FWD_RF;
    endfunction

    // A write to $0 is recorded as a non-writer so it can never be forwarded
    always_comb begin
        id_entry     = '0;
        id_entry.v   = id_valid;
        id_entry.dst = id_dst;
        id_entry.wr  = id_reg_write & (id_dst != '0);
        id_entry.ld  = id_lw;
    end

    pipe_dst_tracker u_tracker (
        .clk_i      (clk),
        .rst_i      (rst),
        .bubble_i   (bubble),
        .id_entry_i (id_entry),
        .ex_o       (ex_e),
        .mem_o      (mem_e),
        .wb_o       (wb_e)
    );

    // Load in EX feeding a source read in ID; flush wins so the redirect proceeds
    always_comb begin
        hz = id_valid & ex_e.ld &
             ((dst_match(ex_e, id_rs) & id_read_rs) | (dst_match(ex_e, id_rt) & id_read_rt));
        stall  = hz & ~flush;
        bubble = hz | flush | ~id_valid;
    end

    // Selects for the instruction entering EX; a bubble reads the regfile
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (!bubble) begin
            fwd_a_d = fwd_sel(id_read_rs, id_rs, ex_e, mem_e);
            fwd_b_d = fwd_sel(id_read_rt, id_rt, ex_e, mem_e);
        end
    end

    // Register forwarding selects and the saturating stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule
